// File: rtl/ahb_tcm_sram_bridge.sv
// AHB-Lite slave that turns zero-wait AHB transfers into single-port TCM SRAM accesses.
// Writes are deferred through a one-entry buffer; reads merge any still-buffered bytes.
module ahb_tcm_sram_bridge #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS,
  input  logic [31:0]   SRAMRDATA
);

  logic          acc, rd_ap, wr_ap;
  logic [AW-1:0] ap_addr;
  logic [3:0]    ap_mask;

  logic          dph_wr, dph_rd;
  logic [AW-1:0] dph_addr;
  logic [3:0]    dph_mask;

  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic [3:0]    pend_mask;
  logic [31:0]   pend_data;

  logic [3:0]    merge_mask, merge_mask_nxt;
  logic [31:0]   merge_data, merge_data_nxt;

  logic          unused_bits;

  assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign acc     = HSEL & HTRANS[1] & HREADY;
  assign rd_ap   = acc & ~HWRITE;
  assign wr_ap   = acc & HWRITE;
  assign ap_addr = HADDR[AW+1:2];

  always_comb begin
    ap_mask = 4'b1111;
    case (HSIZE)
      3'd0:    ap_mask = 4'b0001 << HADDR[1:0];
      3'd1:    ap_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: ap_mask = 4'b1111;
    endcase
  end

  // A read always wins the port; the write it displaces is parked in the pending buffer.
  always_comb begin
    SRAMCS    = 1'b0;
    SRAMWEN   = 4'b0000;
    SRAMADDR  = '0;
    SRAMWDATA = 32'h0;
    if (!HRESET) begin
      if (rd_ap) begin
        SRAMCS   = 1'b1;
        SRAMADDR = ap_addr;
      end else if (pend_valid) begin
        SRAMCS    = 1'b1;
        SRAMWEN   = pend_mask;
        SRAMADDR  = pend_addr;
        SRAMWDATA = pend_data;
      end else if (dph_wr) begin
        SRAMCS    = 1'b1;
        SRAMWEN   = dph_mask;
        SRAMADDR  = dph_addr;
        SRAMWDATA = HWDATA;
      end
    end
  end

  always_comb begin
    merge_mask_nxt = 4'b0000;
    merge_data_nxt = 32'h0;
    if (pend_valid && pend_addr == ap_addr) begin
      merge_mask_nxt = pend_mask;
      merge_data_nxt = pend_data;
    end else if (dph_wr && dph_addr == ap_addr) begin
      merge_mask_nxt = dph_mask;
      merge_data_nxt = HWDATA;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dph_wr     <= 1'b0;
      dph_rd     <= 1'b0;
      dph_addr   <= '0;
      dph_mask   <= 4'b0000;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_mask  <= 4'b0000;
      pend_data  <= 32'h0;
      merge_mask <= 4'b0000;
      merge_data <= 32'h0;
    end else begin
      dph_wr <= wr_ap;
      dph_rd <= rd_ap;
      if (wr_ap) begin
        dph_addr <= ap_addr;
        dph_mask <= ap_mask;
      end
      if (rd_ap) begin
        merge_mask <= merge_mask_nxt;
        merge_data <= merge_data_nxt;
      end else begin
        merge_mask <= 4'b0000;
      end
      if (rd_ap && dph_wr) begin
        pend_valid <= 1'b1;
        pend_addr  <= dph_addr;
        pend_mask  <= dph_mask;
        pend_data  <= HWDATA;
      end else if (pend_valid && !rd_ap) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    if (dph_rd) begin
      for (int i = 0; i < 4; i++)
        HRDATA[8*i +: 8] = merge_mask[i] ? merge_data[8*i +: 8] : SRAMRDATA[8*i +: 8];
    end
  end

  // Only a read can displace a write, and the cycle after a read has no write data phase.
  assert property (@(posedge HCLK) disable iff (HRESET) !(pend_valid && dph_wr && !rd_ap));

endmodule

// File: tb/tb_ahb_tcm_sram_bridge.sv
// Self-checking bench: SRAM model plus a byte-accurate golden memory updated per AHB write.
// Directed scenarios followed by randomized traffic checked against the golden memory.
module tb_ahb_tcm_sram_bridge;
  localparam int AW = 16;

  logic          HCLK, HRESET, HSEL, HWRITE, HREADY;
  logic [31:0]   HADDR, HWDATA;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HREADYOUT, HRESP, SRAMCS;
  logic [31:0]   HRDATA, SRAMWDATA, sram_rdata;
  logic [AW-1:0] SRAMADDR;
  logic [3:0]    SRAMWEN;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [int];
  logic [31:0] gold [int];

  // sampled outputs and expectations from the most recent cycle
  logic        s_cs, s_ready, s_resp, s_pend;
  logic [3:0]  s_wen;
  logic [31:0] s_addr, s_wdata, s_hrdata;
  logic        exp_valid;
  logic [31:0] exp_rdata;

  // transfer currently in its data phase
  logic        p_wr = 0, p_rd = 0;
  logic [31:0] p_addr = 0, p_wdata = 0;
  logic [2:0]  p_size = 0;

  ahb_tcm_sram_bridge #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .SRAMADDR(SRAMADDR),
    .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA), .SRAMCS(SRAMCS), .SRAMRDATA(sram_rdata)
  );

  initial HCLK = 0;
  always #5 HCLK = ~HCLK;

  function automatic logic [31:0] mem_rd(int k);
    return mem.exists(k) ? mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] gold_rd(int k);
    return gold.exists(k) ? gold[k] : 32'h0;
  endfunction

  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN != 4'b0000) begin
        logic [31:0] w;
        w = mem_rd(int'(SRAMADDR));
        for (int b = 0; b < 4; b++)
          if (SRAMWEN[b]) w[8*b +: 8] = SRAMWDATA[8*b +: 8];
        mem[int'(SRAMADDR)] = w;
      end else begin
        sram_rdata <= mem_rd(int'(SRAMADDR));
      end
    end
  end

  task automatic preload(input logic [31:0] baddr, input logic [31:0] val);
    mem[int'(baddr >> 2)]  = val;
    gold[int'(baddr >> 2)] = val;
  endtask

  // One bus cycle: drive an address phase, supply the previous write's data, sample at negedge.
  task automatic do_cycle(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                          input logic [2:0] size, input logic wr, input logic [31:0] wdata,
                          input logic rdy);
    int nb, lo;
    logic [31:0] w;
    HSEL = sel; HTRANS = trans; HADDR = addr; HSIZE = size; HWRITE = wr; HREADY = rdy;
    HWDATA = p_wr ? p_wdata : $urandom;
    @(negedge HCLK);
    s_cs = SRAMCS; s_wen = SRAMWEN; s_addr = 32'(SRAMADDR); s_wdata = SRAMWDATA;
    s_hrdata = HRDATA; s_ready = HREADYOUT; s_resp = HRESP; s_pend = dut.pend_valid;
    exp_valid = p_rd;
    exp_rdata = p_rd ? gold_rd(int'(p_addr >> 2)) : 32'h0;
    if (p_wr) begin
      nb = (p_size == 0) ? 1 : (p_size == 1) ? 2 : 4;
      lo = int'(p_addr[1:0]) / nb * nb;
      w = gold_rd(int'(p_addr >> 2));
      for (int b = lo; b < lo + nb; b++) w[8*b +: 8] = p_wdata[8*b +: 8];
      gold[int'(p_addr >> 2)] = w;
    end
    p_wr = sel & trans[1] & rdy & wr;
    p_rd = sel & trans[1] & rdy & ~wr;
    p_addr = addr; p_size = size; p_wdata = wdata;
    @(posedge HCLK); #1;
  endtask

  task automatic idle();
    do_cycle(1'b0, 2'b00, 32'h0, 3'd0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    @(negedge HCLK);
    checks++;
    if (SRAMCS !== 1'b0 || HRDATA !== 32'h0 || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs cs=%b hrdata=%h readyout=%b resp=%b exp 0/0/1/0",
               SRAMCS, HRDATA, HREADYOUT, HRESP);
    end
    @(posedge HCLK); #1;
    HRESET = 0;
    preload(32'h10, 32'hCAFEF00D);
    do_cycle(1'b1, 2'b10, 32'h10, 3'd2, 1'b1, 32'h99887766, 1'b1);
    HRESET = 1; HWDATA = 32'h99887766;
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h44;
    @(negedge HCLK);
    checks++;
    if (SRAMCS !== 1'b0 || HRDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_midwrite cs=%b hrdata=%h exp 0/00000000", SRAMCS, HRDATA);
    end
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00; HRESET = 0;
    p_wr = 0; p_rd = 0;
    idle();
    do_cycle(1'b1, 2'b10, 32'h10, 3'd2, 1'b0, 32'h0, 1'b1);
    idle();
    checks++;
    if (s_hrdata !== 32'hCAFEF00D || mem_rd(4) !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL reset_write_lost hrdata=%h mem=%h exp cafef00d", s_hrdata, mem_rd(4));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [3];
    d[0] = 32'h11111111; d[1] = 32'h22222222; d[2] = 32'h33333333;
    do_cycle(1'b1, 2'b10, 32'h0, 3'd2, 1'b1, d[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) do_cycle(1'b1, 2'b11, 32'(4*(i+1)), 3'd2, 1'b1, d[i+1], 1'b1);
      else idle();
      checks++;
      if (s_cs !== 1'b1 || s_wen !== 4'b1111 || s_addr !== 32'(i) || s_wdata !== d[i] ||
          s_pend !== 1'b0) begin
        errors++;
        $display("FAIL b2b_write%0d cs=%b wen=%b addr=%h data=%h pend=%b exp 1/1111/%h/%h/0",
                 i, s_cs, s_wen, s_addr, s_wdata, s_pend, i, d[i]);
      end
    end
  endtask

  task automatic test_write_read_merge();
    preload(32'h100, 32'h0);
    do_cycle(1'b1, 2'b10, 32'h101, 3'd0, 1'b1, 32'h0000AB00, 1'b1);
    do_cycle(1'b1, 2'b10, 32'h100, 3'd2, 1'b0, 32'h0, 1'b1);
    checks++;
    if (s_cs !== 1'b1 || s_wen !== 4'b0000 || s_addr !== 32'h40) begin
      errors++;
      $display("FAIL wr_rd_readport cs=%b wen=%b addr=%h exp 1/0000/40", s_cs, s_wen, s_addr);
    end
    idle();
    checks++;
    if (s_hrdata !== 32'h0000AB00) begin
      errors++;
      $display("FAIL wr_rd_merge hrdata=%h exp 0000ab00", s_hrdata);
    end
    checks++;
    if (s_cs !== 1'b1 || s_wen !== 4'b0010 || s_addr !== 32'h40 || s_wdata[15:8] !== 8'hAB) begin
      errors++;
      $display("FAIL wr_rd_drain cs=%b wen=%b addr=%h data=%h exp 1/0010/40/..ab..",
               s_cs, s_wen, s_addr, s_wdata);
    end
  endtask

  task automatic test_sequence();
    preload(32'h20, 32'h0); preload(32'h24, 32'h0); preload(32'h40, 32'h5A5A5A5A);
    do_cycle(1'b1, 2'b10, 32'h20, 3'd2, 1'b1, 32'hDEADBEEF, 1'b1);
    do_cycle(1'b1, 2'b10, 32'h40, 3'd2, 1'b0, 32'h0, 1'b1);
    do_cycle(1'b1, 2'b10, 32'h24, 3'd2, 1'b1, 32'h12345678, 1'b1);
    checks++;
    if (s_wen !== 4'b1111 || s_addr !== 32'h8 || s_wdata !== 32'hDEADBEEF ||
        s_hrdata !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL seq_drain wen=%b addr=%h data=%h hrdata=%h exp 1111/8/deadbeef/5a5a5a5a",
               s_wen, s_addr, s_wdata, s_hrdata);
    end
    do_cycle(1'b1, 2'b10, 32'h24, 3'd2, 1'b0, 32'h0, 1'b1);
    idle();
    checks++;
    if (s_hrdata !== 32'h12345678) begin
      errors++;
      $display("FAIL seq_merge hrdata=%h exp 12345678", s_hrdata);
    end
    idle();
    checks++;
    if (mem_rd(8) !== 32'hDEADBEEF || mem_rd(9) !== 32'h12345678) begin
      errors++;
      $display("FAIL seq_contents m8=%h m9=%h exp deadbeef/12345678", mem_rd(8), mem_rd(9));
    end
  endtask

  task automatic test_halfword();
    preload(32'h30, 32'h11223344);
    do_cycle(1'b1, 2'b10, 32'h32, 3'd1, 1'b1, 32'hBEEF0000, 1'b1);
    idle();
    checks++;
    if (s_wen !== 4'b1100 || s_wdata[31:16] !== 16'hBEEF || s_addr !== 32'hC) begin
      errors++;
      $display("FAIL half_write wen=%b data=%h addr=%h exp 1100/beef..../c", s_wen, s_wdata, s_addr);
    end
    do_cycle(1'b1, 2'b10, 32'h30, 3'd2, 1'b0, 32'h0, 1'b1);
    idle();
    checks++;
    if (s_hrdata !== 32'hBEEF3344) begin
      errors++;
      $display("FAIL half_read hrdata=%h exp beef3344", s_hrdata);
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 10; i++) begin
      case (i % 3)
        0: do_cycle(1'b0, 2'b10, 32'h50, 3'd2, i[0], 32'h0, 1'b1);
        1: do_cycle(1'b1, 2'b00, 32'h54, 3'd2, 1'b1, 32'h0, 1'b1);
        default: do_cycle(1'b1, 2'b10, 32'h58, 3'd2, 1'b0, 32'h0, 1'b0);
      endcase
      if (s_cs !== 1'b0 || s_hrdata !== 32'h0 || s_ready !== 1'b1 || s_resp !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_quiet bad_cycles=%0d exp 0", bad);
    end
  endtask

  task automatic test_random();
    int rd_bad = 0, rd_seen = 0;
    for (int i = 0; i < 400; i++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      sz = 3'($urandom_range(0, 3));
      a  = 32'h200 + 32'($urandom_range(0, 7)) * 4;
      if (sz == 0) a += 32'($urandom_range(0, 3));
      else if (sz == 1) a += 32'($urandom_range(0, 1)) * 2;
      do_cycle(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), a, sz,
               1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) != 0));
      if (exp_valid) begin
        rd_seen++;
        if (s_hrdata !== exp_rdata) begin
          rd_bad++;
          if (rd_bad <= 5) $display("FAIL rand_read cycle=%0d hrdata=%h exp %h", i, s_hrdata, exp_rdata);
        end
      end
    end
    idle(); idle(); idle();
    checks++;
    if (rd_bad != 0 || rd_seen == 0) begin
      errors++;
      $display("FAIL rand_reads bad=%0d seen=%0d exp 0 bad", rd_bad, rd_seen);
    end
  endtask

  task automatic test_final_contents();
    int bad = 0;
    foreach (gold[k]) if (mem_rd(k) !== gold[k]) begin
      bad++;
      if (bad <= 5) $display("FAIL final_mem word=%0h got %h exp %h", k, mem_rd(k), gold[k]);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL final_contents bad_words=%0d exp 0", bad);
    end
  endtask

  initial begin
    HRESET = 1; HSEL = 0; HADDR = 0; HTRANS = 0; HSIZE = 0; HWRITE = 0;
    HWDATA = 0; HREADY = 1; sram_rdata = 0;
    repeat (2) @(posedge HCLK);
    #1;
    test_reset();
    test_back_to_back();
    test_write_read_merge();
    test_sequence();
    test_halfword();
    test_idle();
    test_random();
    test_final_contents();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
